md_sched: RTL and testbench

- Sequencer for the shared multiply/divide resource (HI/LO) in the 5-stage pipeline.
- Accepts MD operations issued from E and models multi-cycle occupancy with a busy counter.
- Commits results to HI/LO when the counter expires.
- Raises a stall request so that any MD-class instruction in D is held while the unit is starting or busy. This request is ORed with the Tuse/Tnew hazard stall.

---
 rtl/md_sched_if.sv | 31 +++
 rtl/md_sched.sv | 132 +++++++++++++
 tb/tb_md_sched.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/md_sched_if.sv
// md_sched_if: bundle between the pipeline and the multiply/divide sequencer.
//   E_start, E_md_op, E_A, E_B : MD instruction issued from the E stage
//   D_is_md                    : the D-stage instruction touches HI/LO
//   busy, HI, LO               : unit occupancy and the architectural HI/LO
//   stop_md                    : stall request, ORed with the hazard stall
//   dbg_state                  : current sequencer state (0 IDLE, 1 BUSY)
// Issue semantics: an E-stage op is presented by E_start=1 for one cycle.
// The unit takes a mult/div only when it is idle. It never pushes back on E.
// Instead, stop_md holds the next MD instruction in D until busy drops.
interface md_sched_if;
  logic        E_start;
  logic [2:0]  E_md_op;
  logic [31:0] E_A;
  logic [31:0] E_B;
  logic        D_is_md;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic        stop_md;
  logic        dbg_state;

  modport master (
    output E_start, E_md_op, E_A, E_B, D_is_md,
    input  busy, HI, LO, stop_md, dbg_state
  );

  modport slave (
    input  E_start, E_md_op, E_A, E_B, D_is_md,
    output busy, HI, LO, stop_md, dbg_state
  );
endinterface

// File: rtl/md_sched.sv
// md_sched: sequencer for the shared HI/LO multiply/divide unit.
// The 64-bit result is computed combinationally in the issue cycle and parked
// in pending_hi/pending_lo. A busy counter then models the multi-cycle
// latency, and the parked value is copied into HI/LO when the counter expires.
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : md_sched_if.slave (E issue, D_is_md, busy, HI, LO, stop_md, dbg_state)
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input logic        clk,
  input logic        rst_n,
  md_sched_if.slave  bus
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d, lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;

  // Opcode decode
  logic op_mul, op_div, op_md, op_sdiv;
  assign op_mul  = (bus.E_md_op == 3'd1) || (bus.E_md_op == 3'd2);
  assign op_div  = (bus.E_md_op == 3'd3) || (bus.E_md_op == 3'd4);
  assign op_md   = op_mul || op_div;
  assign op_sdiv = (bus.E_md_op == 3'd3);

  // Multipliers: sign- or zero-extend to 64 bits, keep the low 64 product bits.
  logic [63:0] mul_s, mul_u;
  assign mul_s = $signed({{32{bus.E_A[31]}}, bus.E_A}) *
                 $signed({{32{bus.E_B[31]}}, bus.E_B});
  assign mul_u = {32'd0, bus.E_A} * {32'd0, bus.E_B};

  // Divider: works on magnitudes and fixes the signs afterwards. This keeps
  // 0x80000000 / -1 well defined, giving q=0x80000000 and r=0.
  // The divisor is forced to 1 when it is zero. That result is never used,
  // because a zero divisor selects the current HI/LO instead.
  logic [31:0] a_mag, b_mag, dvs, q_mag, r_mag, quo, rem;
  logic        b_zero;
  assign b_zero = (bus.E_B == 32'd0);
  assign a_mag  = (op_sdiv && bus.E_A[31]) ? (~bus.E_A + 32'd1) : bus.E_A;
  assign b_mag  = (op_sdiv && bus.E_B[31]) ? (~bus.E_B + 32'd1) : bus.E_B;
  assign dvs    = b_zero ? 32'd1 : b_mag;
  assign q_mag  = a_mag / dvs;
  assign r_mag  = a_mag % dvs;
  assign quo    = (op_sdiv && (bus.E_A[31] ^ bus.E_B[31])) ? (~q_mag + 32'd1) : q_mag;
  assign rem    = (op_sdiv && bus.E_A[31]) ? (~r_mag + 32'd1) : r_mag;

  logic [63:0] result;
  always_comb begin
    result = 64'd0;
    case (bus.E_md_op)
      3'd1:    result = mul_s;
      3'd2:    result = mul_u;
      3'd3,
      3'd4:    result = b_zero ? {hi_q, lo_q} : {rem, quo};
      default: result = 64'd0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    case (state_q)
      IDLE: begin
        if (bus.E_start) begin
          if (op_md) begin
            pend_hi_d = result[63:32];
            pend_lo_d = result[31:0];
            cnt_d     = op_mul ? MULT_LOAD : DIV_LOAD;
            state_d   = BUSY;
          end else if (bus.E_md_op == 3'd5) begin
            hi_d = bus.E_A;
          end else if (bus.E_md_op == 3'd6) begin
            lo_d = bus.E_A;
          end
        end
      end
      BUSY: begin
        // Issue from E is ignored here. stop_md should already prevent it.
        // The <= comparison also drains a zero count instead of wrapping.
        if (cnt_q <= CNT_ONE) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.busy      = (state_q == BUSY);
  assign bus.HI        = hi_q;
  assign bus.LO        = lo_q;
  assign bus.stop_md   = bus.D_is_md & ((state_q == BUSY) | (bus.E_start & op_md));
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_md_sched.sv
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  // Clock and reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  md_sched_if bus();

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Scoreboard
  int          checks = 0;
  int          errors = 0;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi = 32'd0;
  logic [31:0] model_lo = 32'd0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model, built on 64-bit integer arithmetic.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [31:0] hi,
                                        input logic [31:0] lo);
    longint sa, sb, p, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      3'd1: begin p = sa * sb; return 64'(p); end
      3'd2: return ua * ub;
      3'd3: begin
        if (b == 32'd0) return {hi, lo};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      3'd4: begin
        if (b == 32'd0) return {hi, lo};
        uq = ua / ub;
        ur = ua % ub;
        return {ur[31:0], uq[31:0]};
      end
      default: return 64'd0;
    endcase
  endfunction

  // Driver: this is called just after a negedge, in cycle 0 of the operation.
  // inj > 0 drives an illegal MULT start in that busy cycle.
  // Returns in cycle N+1, when a new op may issue back-to-back.
  task automatic run_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic d, input int inj);
    int          n;
    logic [63:0] e;
    n = (op == 3'd1 || op == 3'd2) ? MULT_N : DIV_N;
    bus.E_start = 1'b1;
    bus.E_md_op = op;
    bus.E_A     = a;
    bus.E_B     = b;
    bus.D_is_md = d;
    exp_q.push_back(model(op, a, b, model_hi, model_lo));
    #1;
    check("stop_start", 64'(bus.stop_md), 64'(d));
    check("busy_start", 64'(bus.busy), 64'd0);
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (i == inj) begin
        bus.E_start = 1'b1;
        bus.E_md_op = 3'd1;
        bus.E_A     = $urandom;
        bus.E_B     = $urandom;
      end else begin
        bus.E_start = 1'b0;
      end
      #1;
      check("busy_on", 64'(bus.busy), 64'd1);
      check("dbg_busy", 64'(bus.dbg_state), 64'd1);
      check("hi_hold", 64'(bus.HI), 64'(model_hi));
      check("lo_hold", 64'(bus.LO), 64'(model_lo));
      check("stop_busy", 64'(bus.stop_md), 64'(d));
    end
    @(negedge clk);
    bus.E_start = 1'b0;
    #1;
    check("busy_off", 64'(bus.busy), 64'd0);
    check("stop_off", 64'(bus.stop_md), 64'd0);
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'd1, 64'd0);
    end else begin
      e = exp_q.pop_front();
      check("hi_commit", 64'(bus.HI), 64'(e[63:32]));
      check("lo_commit", 64'(bus.LO), 64'(e[31:0]));
      model_hi = e[63:32];
      model_lo = e[31:0];
    end
  endtask

  // MTHI (op 5) / MTLO (op 6): takes effect next cycle and never stalls.
  task automatic run_mt(input logic [2:0] op, input logic [31:0] a);
    bus.E_start = 1'b1;
    bus.E_md_op = op;
    bus.E_A     = a;
    bus.E_B     = $urandom;
    bus.D_is_md = 1'b1;
    #1;
    check("mt_stop", 64'(bus.stop_md), 64'd0);
    if (op == 3'd5) model_hi = a;
    else            model_lo = a;
    @(negedge clk);
    bus.E_start = 1'b0;
    #1;
    check("mt_busy", 64'(bus.busy), 64'd0);
    check("mt_stop2", 64'(bus.stop_md), 64'd0);
    check("mt_hi", 64'(bus.HI), 64'(model_hi));
    check("mt_lo", 64'(bus.LO), 64'(model_lo));
  endtask

  initial begin
    logic [2:0]  rop;
    logic [31:0] ra, rb;
    rst_n       = 1'b0;
    bus.E_start = 1'b0;
    bus.E_md_op = 3'd0;
    bus.E_A     = 32'd0;
    bus.E_B     = 32'd0;
    bus.D_is_md = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_hi", 64'(bus.HI), 64'd0);
    check("rst_lo", 64'(bus.LO), 64'd0);
    check("rst_state", 64'(bus.dbg_state), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Signed multiply, then back-to-back signed and unsigned divides
    run_md(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 0);
    check("tp_mult_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    check("tp_mult_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFFA);
    run_md(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
    check("tp_div_lo", 64'(bus.LO), 64'h0000_0000_FFFF_FFFD);
    check("tp_div_hi", 64'(bus.HI), 64'h0000_0000_FFFF_FFFF);
    run_md(3'd4, 32'd7, 32'd2, 1'b0, 0);
    check("tp_divu_lo", 64'(bus.LO), 64'd3);
    check("tp_divu_hi", 64'(bus.HI), 64'd1);

    // Stall request with an MD instruction waiting in D
    run_md(3'd2, $urandom, $urandom, 1'b1, 0);

    // MTHI, then an unsigned divide by zero leaves HI/LO untouched
    run_mt(3'd5, 32'h1234_5678);
    run_mt(3'd6, 32'hCAFE_0001);
    run_md(3'd4, $urandom, 32'd0, 1'b1, 0);
    check("dz_hi", 64'(bus.HI), 64'h0000_0000_1234_5678);
    check("dz_lo", 64'(bus.LO), 64'h0000_0000_CAFE_0001);

    // Signed overflow corner
    run_md(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    check("ovf_lo", 64'(bus.LO), 64'h0000_0000_8000_0000);
    check("ovf_hi", 64'(bus.HI), 64'd0);

    // Illegal start in busy cycle 2 of a divide is ignored
    run_md(3'd3, 32'd100, 32'd7, 1'b0, 2);
    check("ill_lo", 64'(bus.LO), 64'd14);
    check("ill_hi", 64'(bus.HI), 64'd2);

    // No-op opcodes 0 and 7 with D_is_md high
    for (int k = 0; k < 2; k++) begin
      bus.E_start = 1'b1;
      bus.E_md_op = (k == 0) ? 3'd0 : 3'd7;
      bus.E_A     = $urandom;
      bus.D_is_md = 1'b1;
      #1;
      check("nop_stop", 64'(bus.stop_md), 64'd0);
      @(negedge clk);
      bus.E_start = 1'b0;
      #1;
      check("nop_busy", 64'(bus.busy), 64'd0);
      check("nop_hi", 64'(bus.HI), 64'(model_hi));
      check("nop_lo", 64'(bus.LO), 64'(model_lo));
    end

    // Asynchronous reset in the middle of a multiply
    bus.E_start = 1'b1;
    bus.E_md_op = 3'd1;
    bus.E_A     = 32'h0001_0000;
    bus.E_B     = 32'h0001_0000;
    bus.D_is_md = 1'b0;
    @(negedge clk);
    bus.E_start = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("pre_rst_busy", 64'(bus.busy), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus.busy), 64'd0);
    check("mid_rst_hi", 64'(bus.HI), 64'd0);
    check("mid_rst_lo", 64'(bus.LO), 64'd0);
    model_hi = 32'd0;
    model_lo = 32'd0;
    #1 rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #1;
      check("post_rst_busy", 64'(bus.busy), 64'd0);
      check("post_rst_hi", 64'(bus.HI), 64'd0);
      check("post_rst_lo", 64'(bus.LO), 64'd0);
    end
    @(negedge clk);
    run_md(3'd1, 32'd2, 32'd3, 1'b0, 0);
    check("fresh_lo", 64'(bus.LO), 64'd6);
    check("fresh_hi", 64'(bus.HI), 64'd0);

    // Random back-to-back operations, including some zero divisors
    for (int i = 0; i < 8; i++) begin
      rop = 3'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      run_md(rop, ra, rb, 1'($urandom_range(0, 1)), 0);
    end

    check("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
